// File: rtl/tow_round_scorer_pkg.sv
// -----------------------------------------------------------------------------
// tow_pkg
// Shared types and constants for the tug-of-war round scorer.
//   state_t   : round-level FSM states (PLAY, HOLD, RESTART, OVER)
//   SEG_BLANK : all segments off for an active-low 7-segment digit
//   SEG_TABLE : digit 0..9 to active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
package tow_pkg;

    typedef enum logic [1:0] {
        PLAY    = 2'd0,
        HOLD    = 2'd1,
        RESTART = 2'd2,
        OVER    = 2'd3
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry N is the pattern for digit N (entry 0 is the rightmost element).
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/tow_round_scorer_seg7_digit.sv
// -----------------------------------------------------------------------------
// seg7_digit
// Converts a 4-bit value to active-low 7-segment drive {g..a}.
//   value : input  [3:0] digit to show (0..9; anything larger shows blank)
//   seg   : output [6:0] active-low segment pattern
// -----------------------------------------------------------------------------
module seg7_digit
    import tow_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        if (value <= 4'd9) begin
            seg = SEG_TABLE[value];
        end else begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/tow_round_scorer.sv
// -----------------------------------------------------------------------------
// tow_round_scorer
// Watches the tug-of-war end lights and player presses, awards round wins,
// keeps per-player scores, requests a playfield restart after each round and
// declares the match over once a player reaches MAX_SCORE.
//
// Ports:
//   clk         : input        system clock
//   Reset       : input        synchronous, active-high reset
//   L, R        : input        conditioned one-cycle player presses
//   leftEndOn   : input        leftmost playfield light
//   rightEndOn  : input        rightmost playfield light
//   scoreLeft   : output [SCORE_W-1:0] left-player score
//   scoreRight  : output [SCORE_W-1:0] right-player score
//   roundReset  : output       one-cycle restart request to the playfield
//   gameOver    : output       match finished
//   winnerLeft  : output       left player won the last round / match
//   hexLeft     : output [6:0] active-low digit for scoreLeft
//   hexRight    : output [6:0] active-low digit for scoreRight
//
// Optional feature macro: TOW_SCORER_WINFLASH_EN
//   When defined, the winner's digit blinks (blank every other cycle) while
//   the block is in HOLD or OVER.
// -----------------------------------------------------------------------------
module tow_round_scorer
    import tow_pkg::*;
#(
    parameter int MAX_SCORE   = 7,
    parameter int SCORE_W     = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               L,
    input  logic               R,
    input  logic               leftEndOn,
    input  logic               rightEndOn,
    output logic [SCORE_W-1:0] scoreLeft,
    output logic [SCORE_W-1:0] scoreRight,
    output logic               roundReset,
    output logic               gameOver,
    output logic               winnerLeft,
    output logic [6:0]         hexLeft,
    output logic [6:0]         hexRight
);

    localparam int                 HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(MAX_SCORE);

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [SCORE_W-1:0] score_left_q, score_left_d;
    logic [SCORE_W-1:0] score_right_q, score_right_d;
    logic               winner_left_q, winner_left_d;
    logic               round_reset_q, round_reset_d;
    logic               game_over_q, game_over_d;
    logic               left_win, right_win;

    // A simultaneous L and R press is a tie and neither rule fires.
    assign left_win  = L & ~R & leftEndOn;
    assign right_win = R & ~L & rightEndOn;

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        winner_left_d = winner_left_q;

        case (state_q)
            PLAY: begin
                if (left_win) begin
                    score_left_d  = score_left_q + 1'b1;
                    winner_left_d = 1'b1;
                    if (score_left_d == SCORE_MAX) begin
                        state_d = OVER;
                    end else begin
                        state_d    = HOLD;
                        hold_cnt_d = HOLD_LOAD;
                    end
                end else if (right_win) begin
                    score_right_d = score_right_q + 1'b1;
                    winner_left_d = 1'b0;
                    if (score_right_d == SCORE_MAX) begin
                        state_d = OVER;
                    end else begin
                        state_d    = HOLD;
                        hold_cnt_d = HOLD_LOAD;
                    end
                end
            end
            // Counter is loaded with HOLD_CYCLES-1 so RESTART is entered
            // exactly HOLD_CYCLES edges after the winning edge.
            HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = RESTART;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            RESTART: state_d = PLAY;
            OVER:    state_d = OVER;
            default: state_d = PLAY;
        endcase

        // Moore outputs registered from the next state so they line up
        // with the state they describe.
        round_reset_d = (state_d == RESTART);
        game_over_d   = (state_d == OVER);
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q       <= PLAY;
            hold_cnt_q    <= '0;
            score_left_q  <= '0;
            score_right_q <= '0;
            winner_left_q <= 1'b0;
            round_reset_q <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
            winner_left_q <= winner_left_d;
            round_reset_q <= round_reset_d;
            game_over_q   <= game_over_d;
        end
    end

    assign scoreLeft  = score_left_q;
    assign scoreRight = score_right_q;
    assign roundReset = round_reset_q;
    assign gameOver   = game_over_q;
    assign winnerLeft = winner_left_q;

    logic [3:0] digit_left, digit_right;
    logic [6:0] seg_left, seg_right;

    assign digit_left  = 4'(score_left_q);
    assign digit_right = 4'(score_right_q);

    seg7_digit u_seg_left (
        .value (digit_left),
        .seg   (seg_left)
    );

    seg7_digit u_seg_right (
        .value (digit_right),
        .seg   (seg_right)
    );

`ifdef TOW_SCORER_WINFLASH_EN
    logic toggle_q, toggle_d;
    logic flash_blank;

    // Toggle only runs while in HOLD/OVER; it reads 0 on the first cycle of
    // either state because it is forced low everywhere else.
    always_comb begin
        toggle_d = 1'b0;
        if (state_q == HOLD || state_q == OVER) begin
            toggle_d = ~toggle_q;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            toggle_q <= 1'b0;
        end else begin
            toggle_q <= toggle_d;
        end
    end

    assign flash_blank = (state_q == HOLD || state_q == OVER) && toggle_q;
    assign hexLeft     = (flash_blank &&  winner_left_q) ? SEG_BLANK : seg_left;
    assign hexRight    = (flash_blank && !winner_left_q) ? SEG_BLANK : seg_right;
`else
    assign hexLeft  = seg_left;
    assign hexRight = seg_right;
`endif

endmodule

// File: doc/tow_round_scorer.md
Name: tow_round_scorer

Overview:
- Sits directly downstream of the tug-of-war playfield lights, including both end lights.
- Detects when the light is pushed off an end, awards the point, and counts per-player scores.
- Pulses a round-restart request back to the playfield and declares match over at MAX_SCORE.
- Drives two active-low 7-segment score digits.

Parameters:
- MAX_SCORE, 7, wins needed to end the match; legal range 1..9.
- SCORE_W, 4, score counter width; must satisfy 2^SCORE_W > MAX_SCORE.
- HOLD_CYCLES, 4, cycles the win state is held before restart request; must be >= 1.

Ports:
- clk  input  1  system clock
- Reset  input  1  synchronous, active-high reset
- L  input  1  left-player press, one-cycle pulse (already conditioned)
- R  input  1  right-player press, one-cycle pulse
- leftEndOn  input  1  leftmost playfield light state
- rightEndOn  input  1  rightmost playfield light state
- scoreLeft  output  SCORE_W  left-player score
- scoreRight  output  SCORE_W  right-player score
- roundReset  output  1  one-cycle restart request to playfield lights
- gameOver  output  1  match finished
- winnerLeft  output  1  left player won the last round or match
- hexLeft  output  7  active-low segments {g..a} for scoreLeft
- hexRight  output  7  active-low segments for scoreRight

Behaviour:
- Clocking: clk is the clock. Reset is synchronous, active-high. Reset has priority over all other events.
- Reset values:
  - state = PLAY
  - scoreLeft = scoreRight = 0
  - roundReset = 0, gameOver = 0, winnerLeft = 0
  - hold counter = 0
  - hexLeft = hexRight = pattern for "0" (7'b1000000)
- Win conditions, evaluated only in PLAY:
  - Left win: L & ~R & leftEndOn.
  - Right win: R & ~L & rightEndOn.
  - L & R in the same cycle is a no-op (tie), even if an end light is on.
  - Both end lights on is impossible in normal play. If it occurs, only the pressed side's rule applies.
- PLAY:
  - On a win, at the same clock edge: the winner's score increments by 1 and winnerLeft is set. The new score is visible the cycle after the press (latency 1).
  - If the new score == MAX_SCORE, go to OVER; otherwise go to HOLD and load the hold counter with HOLD_CYCLES-1.
- HOLD:
  - Presses are ignored.
  - The counter decrements each cycle. At 0, go to RESTART.
  - Time from the win edge to RESTART entry is HOLD_CYCLES cycles.
- RESTART:
  - roundReset = 1 for exactly this one cycle (a Moore output), then go to PLAY.
  - Presses are ignored in this cycle.
- OVER:
  - gameOver = 1 and scores are frozen. roundReset = 0.
  - The state stays OVER until Reset.
- Scores never exceed MAX_SCORE. There is no wrap-around.
- Reset asserted mid-HOLD or mid-RESTART returns the block to PLAY with zero scores. No roundReset pulse is emitted.
- The hex digits are combinational from the registered scores, so they update in the same cycle as the score.

Optional Feature:
- Macro: TOW_SCORER_WINFLASH_EN.
- When defined:
  - In HOLD and OVER, the winner's hex digit blanks (7'h7F) on alternate cycles, driven by a 1-bit toggle register.
  - The toggle resets to 0 (digit shown) and is cleared on entry to HOLD.
- When undefined:
  - Digits are always steady and no toggle register exists.

Decomposition:
- Package tow_pkg holds:
  - state enum {PLAY, HOLD, RESTART, OVER}, 2 bits
  - SEG_BLANK = 7'h7F
  - the 10-entry digit-to-segment constant array
- Sub-module seg7_digit: 4-bit value in, 7-bit active-low segments out. Instantiated twice.
- The FSM and counters stay in the top module.

Test Plan:
- Reset, then leftEndOn=1 and a single-cycle L pulse:
  - scoreLeft=1 and winnerLeft=1 on the next cycle.
  - roundReset high exactly once, HOLD_CYCLES=4 cycles later.
  - hexLeft=7'b1111001.
- rightEndOn=1 with L and R pulsed in the same cycle: no score change, no roundReset, state stays PLAY.
- Right wins 7 times, each separated by a RESTART: scoreRight=7, gameOver=1, no roundReset after the 7th win, and further R pulses leave the score at 7.
- L pulse with leftEndOn=1 during HOLD: ignored, scoreLeft unchanged.
- Reset asserted during HOLD with scoreLeft=3: next cycle all scores are 0, state is PLAY, and roundReset never pulses.
- TOW_SCORER_WINFLASH_EN defined, left win: hexLeft alternates between the digit pattern and 7'h7F every cycle through HOLD; hexRight stays steady.
